// File: rtl/dmem_dump_pkg.sv
// Shared types and channel tags for the data-memory drain engine.
package dmem_dump_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, RD, SEND, CSUM, FIN} dump_state_t;

  localparam logic       CH_COL  = 1'b0;
  localparam logic       CH_SUM  = 1'b1;
  localparam logic [1:0] CH_CSUM = 2'b11;

endpackage

// File: rtl/dmem_dump_csum.sv
// Running mod-2^DW sum of the words read during one dump (used only when
// DMEM_DUMP_CHECKSUM_EN is defined).
module dump_csum #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          add,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      sum <= '0;
    else if (clr) sum <= '0;
    else if (add) sum <= sum + din;
  end

endmodule

// File: rtl/dmem_dump.sv
// Drains the col/sum channels of the data memory over a valid/ready stream.
// Optional trailing checksum word: define DMEM_DUMP_CHECKSUM_EN.
module dmem_dump
  import dmem_dump_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   count,
  input  logic [1:0]    chmask,
  input  logic          abort,
  output logic [AW-1:0] mem_ad,
  output logic          mem_ch,
  output logic          mem_dms,
  input  logic [DW-1:0] mem_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_ch,
  output logic [AW-1:0] out_ad,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  dump_state_t   state, state_nx;
  logic [AW:0]   cnt;
  logic [1:0]    mask;
  logic [AW-1:0] ad;
  logic          ch;
  logic          hs, last_addr, last_ch, last_word;

  function automatic logic [AW:0] clamp_count(input logic [AW:0] c);
    return (c > DEPTH) ? DEPTH : c;
  endfunction

  assign hs        = out_valid & out_ready;
  assign last_addr = ({1'b0, ad} == cnt - 1'b1);
  assign last_ch   = (ch == CH_SUM) || !mask[1];
  assign last_word = last_addr && last_ch;

`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [DW-1:0] acc;

  dump_csum #(.DW(DW)) u_csum (
    .clk (clk),
    .rst (rst),
    .clr (state == SETUP),
    .add (state == RD),
    .din (mem_rd),
    .sum (acc)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = SETUP;
      SETUP: state_nx = (cnt != '0 && mask != 2'b00) ? RD : FIN;
      RD:    state_nx = SEND;
      SEND: begin
        if (hs) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
          state_nx = last_word ? CSUM : RD;
`else
          state_nx = last_word ? FIN : RD;
`endif
        end
      end
`ifdef DMEM_DUMP_CHECKSUM_EN
      CSUM:  if (hs) state_nx = FIN;
`endif
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Abort overrides every transition, including a start seen in IDLE.
    if (abort) state_nx = IDLE;
  end

  // Read port is driven only in RD so the core owns the memory otherwise.
  always_comb begin
    mem_dms = (state == RD);
    mem_ad  = mem_dms ? ad : '0;
    mem_ch  = mem_dms ? ch : CH_COL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      mask <= 2'b00;
      ad   <= '0;
      ch   <= CH_COL;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt  <= clamp_count(count);
          mask <= chmask;
        end
        SETUP: begin
          ad <= '0;
          ch <= mask[0] ? CH_COL : CH_SUM;
        end
        SEND: if (hs) begin
          // Address wraps within AW bits; the channel steps col -> sum.
          if (last_addr) begin
            ad <= '0;
            ch <= CH_SUM;
          end else begin
            ad <= ad + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= 2'b00;
      out_ad    <= '0;
      out_last  <= 1'b0;
    end else begin
      busy      <= (state_nx != IDLE);
      done      <= (state_nx == FIN);
      out_valid <= (state_nx == SEND) || (state_nx == CSUM);
      if (state == RD) begin
        out_data <= mem_rd;
        out_ch   <= {1'b0, ch};
        out_ad   <= ad;
`ifdef DMEM_DUMP_CHECKSUM_EN
        out_last <= 1'b0;
`else
        out_last <= last_word;
`endif
      end
`ifdef DMEM_DUMP_CHECKSUM_EN
      if (state == SEND && state_nx == CSUM) begin
        out_data <= acc;
        out_ch   <= CH_CSUM;
        out_ad   <= '0;
        out_last <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_dump.sv
// Directed bench for dmem_dump; expectations follow DMEM_DUMP_CHECKSUM_EN.
module tb_dmem_dump;

  localparam int AW = 8;
  localparam int DW = 16;
  typedef logic [DW+AW+2:0] word_t;  // {last, ch, ad, data}

  logic          clk = 1'b0;
  logic          rst, start, abort, out_ready;
  logic [AW:0]   count;
  logic [1:0]    chmask;
  logic [AW-1:0] mem_ad, out_ad;
  logic          mem_ch, mem_dms, out_valid, out_last, busy, done;
  logic [DW-1:0] mem_rd, out_data;
  logic [1:0]    out_ch;

  logic [DW-1:0] col_mem [256];
  logic [DW-1:0] sum_mem [256];

  word_t got_w[$];
  word_t exp_w[$];
  int    n_cmp = 0, n_bad = 0;
  int    done_cyc, valid_cyc, unstable, done_cnt;
  bit    timed_out;

  dmem_dump #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .chmask(chmask),
    .abort(abort), .mem_ad(mem_ad), .mem_ch(mem_ch), .mem_dms(mem_dms),
    .mem_rd(mem_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_ad(out_ad),
    .out_last(out_last), .busy(busy), .done(done)
  );

  assign mem_rd = mem_ch ? sum_mem[mem_ad] : col_mem[mem_ad];
  always #5 clk = ~clk;

  function automatic word_t pk(input logic l, input logic [1:0] c,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {l, c, a, d};
  endfunction

  task automatic do_start(input logic [AW:0] c, input logic [1:0] m);
    @(negedge clk);
    count = c; chmask = m; start = 1'b1;
  endtask

  // Records every completed handshake until done or the cycle budget expires.
  task automatic collect(input int max_cyc, input bit rnd);
    word_t prev;
    bit    hold;
    got_w.delete();
    done_cyc = 0; valid_cyc = 0; unstable = 0; done_cnt = 0; hold = 0; prev = '0;
    for (int cyc = 1; cyc <= max_cyc && done_cnt == 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (hold && (!out_valid || pk(out_last, out_ch, out_ad, out_data) !== prev))
        unstable++;
      if (out_valid && valid_cyc == 0) valid_cyc = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) got_w.push_back(pk(out_last, out_ch, out_ad, out_data));
      hold = out_valid && !out_ready;
      prev = pk(out_last, out_ch, out_ad, out_data);
    end
    timed_out = (done_cnt == 0);
    out_ready = 1'b1;
  endtask

  // Reference dump: channels in order col then sum, addresses 0..count-1.
  task automatic build_exp(input int cnt, input logic [1:0] m);
    int c;
    logic [DW-1:0] s, d;
    c = (cnt > 256) ? 256 : cnt;
    s = '0;
    exp_w.delete();
    for (int chn = 0; chn < 2; chn++)
      if (m[chn])
        for (int a = 0; a < c; a++) begin
          d = (chn == 1) ? sum_mem[a] : col_mem[a];
          s = s + d;
          exp_w.push_back(pk(1'b0, 2'(chn), AW'(a), d));
        end
`ifdef DMEM_DUMP_CHECKSUM_EN
    exp_w.push_back(pk(1'b1, 2'b11, '0, s));
`else
    if (exp_w.size() > 0) exp_w[exp_w.size()-1][DW+AW+2] = 1'b1;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_ad !== '0)    begin n_bad++; $display("FAIL rst_mem_ad got %0h want 0", mem_ad); end
    n_cmp++; if (mem_ch !== 1'b0)  begin n_bad++; $display("FAIL rst_mem_ch got %0b want 0", mem_ch); end
    n_cmp++; if (mem_dms !== 1'b0) begin n_bad++; $display("FAIL rst_mem_dms got %0b want 0", mem_dms); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== '0)  begin n_bad++; $display("FAIL rst_out_data got %0h want 0", out_data); end
    n_cmp++; if (out_ch !== 2'b00) begin n_bad++; $display("FAIL rst_out_ch got %0b want 0", out_ch); end
    n_cmp++; if (out_ad !== '0)    begin n_bad++; $display("FAIL rst_out_ad got %0h want 0", out_ad); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL rst_out_last got %0b want 0", out_last); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL rst_busy got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0)    begin n_bad++; $display("FAIL rst_done got %0b want 0", done); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    col_mem[0] = 16'd5; col_mem[1] = 16'd16; col_mem[2] = 16'd8;
    do_start(9'd3, 2'b01);
    collect(40, 1'b0);
    exp_w.delete();
    exp_w.push_back(pk(1'b0, 2'd0, 8'd0, 16'd5));
    exp_w.push_back(pk(1'b0, 2'd0, 8'd1, 16'd16));
`ifdef DMEM_DUMP_CHECKSUM_EN
    exp_w.push_back(pk(1'b0, 2'd0, 8'd2, 16'd8));
    exp_w.push_back(pk(1'b1, 2'b11, 8'd0, 16'd29));
    n_cmp++; if (done_cyc !== 9) begin n_bad++; $display("FAIL single_done_cyc got %0d want 9", done_cyc); end
`else
    exp_w.push_back(pk(1'b1, 2'd0, 8'd2, 16'd8));
    n_cmp++; if (done_cyc !== 8) begin n_bad++; $display("FAIL single_done_cyc got %0d want 8", done_cyc); end
`endif
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL single_timeout got no done want done"); end
    n_cmp++; if (valid_cyc !== 3) begin n_bad++; $display("FAIL single_first_valid got %0d want 3", valid_cyc); end
    n_cmp++; if (got_w.size() !== exp_w.size()) begin n_bad++; $display("FAIL single_len got %0d want %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      n_cmp++; if (got_w[i] !== exp_w[i]) begin n_bad++; $display("FAIL single_word[%0d] got %h want %h", i, got_w[i], exp_w[i]); end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL single_after got busy=%0b done=%0b want 0/0", busy, done); end
  endtask

  task automatic test_two_ch();
    col_mem[0] = 16'd7; col_mem[1] = 16'd22; sum_mem[0] = 16'd1; sum_mem[1] = 16'd4;
    do_start(9'd2, 2'b11);
    collect(40, 1'b0);
    exp_w.delete();
    exp_w.push_back(pk(1'b0, 2'd0, 8'd0, 16'd7));
    exp_w.push_back(pk(1'b0, 2'd0, 8'd1, 16'd22));
    exp_w.push_back(pk(1'b0, 2'd1, 8'd0, 16'd1));
`ifdef DMEM_DUMP_CHECKSUM_EN
    exp_w.push_back(pk(1'b0, 2'd1, 8'd1, 16'd4));
    exp_w.push_back(pk(1'b1, 2'b11, 8'd0, 16'd34));
`else
    exp_w.push_back(pk(1'b1, 2'd1, 8'd1, 16'd4));
`endif
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL two_ch_timeout got no done want done"); end
    n_cmp++; if (got_w.size() !== exp_w.size()) begin n_bad++; $display("FAIL two_ch_len got %0d want %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      n_cmp++; if (got_w[i] !== exp_w[i]) begin n_bad++; $display("FAIL two_ch_word[%0d] got %h want %h", i, got_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_start_busy();
    col_mem[0] = 16'd41; col_mem[1] = 16'd42;
    do_start(9'd2, 2'b01);
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; count = 9'd1; chmask = 2'b10;
    collect(40, 1'b0);
    exp_w.delete();
    exp_w.push_back(pk(1'b0, 2'd0, 8'd0, 16'd41));
`ifdef DMEM_DUMP_CHECKSUM_EN
    exp_w.push_back(pk(1'b0, 2'd0, 8'd1, 16'd42));
    exp_w.push_back(pk(1'b1, 2'b11, 8'd0, 16'd83));
`else
    exp_w.push_back(pk(1'b1, 2'd0, 8'd1, 16'd42));
`endif
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL start_busy_timeout got no done want done"); end
    n_cmp++; if (got_w.size() !== exp_w.size()) begin n_bad++; $display("FAIL start_busy_len got %0d want %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      n_cmp++; if (got_w[i] !== exp_w[i]) begin n_bad++; $display("FAIL start_busy_word[%0d] got %h want %h", i, got_w[i], exp_w[i]); end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_busy_idle got busy=%0b want 0", busy); end
  endtask

  task automatic test_ready_toggle();
    for (int i = 0; i < 5; i++) begin
      col_mem[i] = 16'(10 + i);
      sum_mem[i] = 16'(20 + i);
    end
    do_start(9'd5, 2'b11);
    collect(400, 1'b1);
    build_exp(5, 2'b11);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL ready_timeout got no done want done"); end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL ready_stable got %0d changes want 0", unstable); end
    n_cmp++; if (got_w.size() !== exp_w.size()) begin n_bad++; $display("FAIL ready_len got %0d want %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      n_cmp++; if (got_w[i] !== exp_w[i]) begin n_bad++; $display("FAIL ready_word[%0d] got %h want %h", i, got_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_zero();
    do_start(9'd0, 2'b11);
    collect(20, 1'b0);
    n_cmp++; if (valid_cyc !== 0) begin n_bad++; $display("FAIL zero_cnt_valid got cycle %0d want never", valid_cyc); end
    n_cmp++; if (done_cyc !== 2) begin n_bad++; $display("FAIL zero_cnt_done got %0d want 2", done_cyc); end
    do_start(9'd3, 2'b00);
    collect(20, 1'b0);
    n_cmp++; if (valid_cyc !== 0) begin n_bad++; $display("FAIL zero_mask_valid got cycle %0d want never", valid_cyc); end
    n_cmp++; if (done_cyc !== 2) begin n_bad++; $display("FAIL zero_mask_done got %0d want 2", done_cyc); end
  endtask

  task automatic test_abort();
    bit found;
    int seen;
    for (int i = 0; i < 4; i++) col_mem[i] = 16'(100 + i);
    do_start(9'd4, 2'b01);
    found = 0;
    for (int cyc = 0; cyc < 30 && !found; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_ad == 8'd1) begin
        out_ready = 1'b0; abort = 1'b1; found = 1;
      end else begin
        out_ready = 1'b1;
      end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL abort_reach got no word 1 want word 1"); end
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid got %0b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %0b want 0", busy); end
    seen = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (done || out_valid) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_quiet got %0d active cycles want 0", seen); end
    start = 1'b1; abort = 1'b1; count = 9'd2; chmask = 2'b01;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_vs_start got busy=%0b want 0", busy); end
    do_start(9'd2, 2'b01);
    collect(40, 1'b0);
    build_exp(2, 2'b01);
    n_cmp++; if (got_w.size() !== exp_w.size()) begin n_bad++; $display("FAIL abort_redump_len got %0d want %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      n_cmp++; if (got_w[i] !== exp_w[i]) begin n_bad++; $display("FAIL abort_redump[%0d] got %h want %h", i, got_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_rst_full();
    for (int i = 0; i < 256; i++) begin
      col_mem[i] = 16'(i * 7 + 3);
      sum_mem[i] = 16'(i) ^ 16'h5a00;
    end
    do_start(9'd4, 2'b01);
    repeat (5) begin @(negedge clk); start = 1'b0; end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      n_bad++; $display("FAIL rst_mid got valid=%0b busy=%0b data=%0h want 0/0/0", out_valid, busy, out_data);
    end
    @(negedge clk); rst = 1'b0;
    do_start(9'h100, 2'b11);
    collect(1200, 1'b0);
    build_exp(256, 2'b11);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL full_timeout got no done want done"); end
    n_cmp++; if (got_w.size() !== exp_w.size()) begin n_bad++; $display("FAIL full_len got %0d want %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      n_cmp++; if (got_w[i] !== exp_w[i]) begin n_bad++; $display("FAIL full_word[%0d] got %h want %h", i, got_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_clamp();
    do_start(9'h1a0, 2'b01);
    collect(700, 1'b0);
    build_exp(416, 2'b01);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL clamp_timeout got no done want done"); end
    n_cmp++; if (got_w.size() !== exp_w.size()) begin n_bad++; $display("FAIL clamp_len got %0d want %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      n_cmp++; if (got_w[i] !== exp_w[i]) begin n_bad++; $display("FAIL clamp_word[%0d] got %h want %h", i, got_w[i], exp_w[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    count = '0; chmask = 2'b00;
    for (int i = 0; i < 256; i++) begin
      col_mem[i] = '0;
      sum_mem[i] = '0;
    end
    test_reset();
    test_single();
    test_two_ch();
    test_start_busy();
    test_ready_toggle();
    test_zero();
    test_abort();
    test_rst_full();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
